// File: rtl/div_ctrl_pkg.sv
// Shared types and defaults for the divider issue controller.
// No logic; state encoding and flush-drain default only.
// No flow control of its own.
package div_ctrl_pkg;

    localparam int DRAIN_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } div_state_e;

endpackage

// File: rtl/alu_defines.vh
`ifndef ALU_DEFINES_VH
`define ALU_DEFINES_VH

// EX-stage ALU control encodings for the divide instructions
`define DIV_CONTROL  6'b011010
`define DIVU_CONTROL 6'b011011

`endif

// File: rtl/div_issue_ctrl.sv
// Issues DIV/DIVU from EX to the external 32-cycle divider and returns {hi,lo}; DIV_ZERO_FAST_EN enables zero-divisor bypass.
// Start/stall combinational at issue; result write at divider ready (35 cycles, 3 for a zero divisor, 0 with bypass).
// Stalls the pipeline while busy and for one DRAIN cycle; flush annuls the divide and holds annul DRAIN_CYCLES cycles.
`include "alu_defines.vh"

module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic        valid_i,
    input  logic        flush_i,
    output logic [5:0]  div_op_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] flush_cnt;
    logic [5:0]       op_q;
    logic [31:0]      opa_q, opb_q;
    logic             latch_en;
    logic             div_req;

    assign div_req = valid_i && !flush_i &&
                     ((aluop_i == `DIV_CONTROL) || (aluop_i == `DIVU_CONTROL));

    // State register; reset abandons any divide in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture op and operands at issue so the divider sees stable inputs while EX is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else if (latch_en) begin
            op_q  <= aluop_i;
            opa_q <= reg1_i;
            opb_q <= reg2_i;
        end
    end

    // Count cycles spent in FLUSH; cleared in every other state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (state_q == FLUSH) begin
            flush_cnt <= flush_cnt + 1'b1;
        end else begin
            flush_cnt <= '0;
        end
    end

    // Next state and all outputs; everything is forced low while rst is high
    always_comb begin
        state_d       = state_q;
        latch_en      = 1'b0;
        div_op_o      = '0;
        div_opdata1_o = '0;
        div_opdata2_o = '0;
        div_start_o   = 1'b0;
        div_annul_o   = 1'b0;
        stallreq_o    = 1'b0;
        whilo_o       = 1'b0;
        hi_o          = '0;
        lo_o          = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (div_req) begin
`ifdef DIV_ZERO_FAST_EN
                        if (reg2_i == '0) begin
                            // zero divisor: write hi=lo=0 now, divider untouched
                            whilo_o = 1'b1;
                        end else begin
                            div_start_o   = 1'b1;
                            stallreq_o    = 1'b1;
                            div_op_o      = aluop_i;
                            div_opdata1_o = reg1_i;
                            div_opdata2_o = reg2_i;
                            latch_en      = 1'b1;
                            state_d       = BUSY;
                        end
`else
                        div_start_o   = 1'b1;
                        stallreq_o    = 1'b1;
                        div_op_o      = aluop_i;
                        div_opdata1_o = reg1_i;
                        div_opdata2_o = reg2_i;
                        latch_en      = 1'b1;
                        state_d       = BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        div_annul_o = 1'b1;
                        state_d     = FLUSH;
                    end else begin
                        div_start_o   = 1'b1;
                        div_op_o      = op_q;
                        div_opdata1_o = opa_q;
                        div_opdata2_o = opb_q;
                        if (div_ready_i) begin
                            whilo_o = 1'b1;
                            hi_o    = div_result_i[63:32];
                            lo_o    = div_result_i[31:0];
                            state_d = DRAIN;
                        end else begin
                            stallreq_o = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // start low for one cycle lets the divider return to free
                    if (flush_i) begin
                        div_annul_o = 1'b1;
                        state_d     = FLUSH;
                    end else begin
                        stallreq_o = div_req;
                        state_d    = IDLE;
                    end
                end
                FLUSH: begin
                    div_annul_o = 1'b1;
                    if (flush_cnt == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized self-checking bench for div_issue_ctrl with a behavioural divider stand-in.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
// Build with +define+DIV_ZERO_FAST_EN to check the zero-divisor bypass.
module tb_div_issue_ctrl;

    localparam logic [5:0] OP_DIV  = 6'b011010;
    localparam logic [5:0] OP_DIVU = 6'b011011;
    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  aluop_i = '0;
    logic [31:0] reg1_i = '0, reg2_i = '0;
    logic        valid_i = 1'b0, flush_i = 1'b0;
    logic [5:0]  div_op_o;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        div_start_o, div_annul_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stallreq_o, whilo_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    div_issue_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
        .valid_i(valid_i), .flush_i(flush_i), .div_op_o(div_op_o),
        .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: {remainder, quotient}, truncating toward zero; zero divisor gives 0
    function automatic logic [63:0] ref_divide(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (op == OP_DIV) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Cycle (relative to issue) at which the HI/LO write is expected
    function automatic int ref_latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) return 0;
`endif
        return (b == 32'd0) ? 3 : 35;
    endfunction

    // Divider stand-in: samples operands on the first start cycle, ready after 35 (or 3) cycles, held until start drops
    logic        dv_run;
    int          dv_cnt;
    logic [5:0]  dv_op;
    logic [31:0] dv_a, dv_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_run <= 1'b0; dv_cnt <= 0; dv_op <= '0; dv_a <= '0; dv_b <= '0;
        end else if (!div_start_o || div_annul_o) begin
            dv_run <= 1'b0; dv_cnt <= 0;
        end else if (!dv_run) begin
            dv_run <= 1'b1; dv_cnt <= 1;
            dv_op <= div_op_o; dv_a <= div_opdata1_o; dv_b <= div_opdata2_o;
        end else begin
            dv_cnt <= dv_cnt + 1;
        end
    end
    assign div_ready_i  = dv_run && (dv_cnt >= ((dv_b == 32'd0) ? 3 : 35));
    assign div_result_i = dv_run ? ref_divide(dv_op, dv_a, dv_b) : 64'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide (optionally arriving during DRAIN) and check every cycle up to the write
    task automatic run_div(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit pre_drain, input string tag);
        int lat;
        logic [63:0] exp_r;
        lat   = ref_latency(b);
        exp_r = ref_divide(op, a, b);
        aluop_i = op; reg1_i = a; reg2_i = b; valid_i = 1'b1;
        if (pre_drain) begin
            @(negedge clk);
            checks++;
            if (stallreq_o !== 1'b1 || div_start_o !== 1'b0 || whilo_o !== 1'b0) begin
                errors++;
                $display("FAIL %s_drain_stall: stall=%b start=%b whilo=%b, want 1 0 0", tag, stallreq_o, div_start_o, whilo_o);
            end
            step();
        end
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            checks++;
            if (c < lat) begin
                if (stallreq_o !== 1'b1 || whilo_o !== 1'b0 || div_start_o !== 1'b1 ||
                    div_op_o !== op || div_opdata1_o !== a || div_opdata2_o !== b) begin
                    errors++;
                    $display("FAIL %s_busy c%0d: stall=%b whilo=%b start=%b op=%h a=%h b=%h, want 1 0 1 %h %h %h",
                             tag, c, stallreq_o, whilo_o, div_start_o, div_op_o, div_opdata1_o, div_opdata2_o, op, a, b);
                end
            end else begin
                if (whilo_o !== 1'b1 || stallreq_o !== 1'b0 || hi_o !== exp_r[63:32] ||
                    lo_o !== exp_r[31:0] || div_start_o !== (lat != 0)) begin
                    errors++;
                    $display("FAIL %s_write c%0d: whilo=%b stall=%b start=%b hi=%h lo=%h, want 1 0 %b %h %h",
                             tag, c, whilo_o, stallreq_o, div_start_o, hi_o, lo_o, (lat != 0), exp_r[63:32], exp_r[31:0]);
                end
            end
            step();
            // EX operands change while busy; the divider must keep the issued ones
            if (c < lat) begin
                reg1_i = $urandom;
                reg2_i = $urandom;
            end
        end
        valid_i = 1'b0; aluop_i = '0; reg1_i = '0; reg2_i = '0;
    endtask

    // One cycle with no request: every output must be at its idle value
    task automatic idle_check(input string tag);
        @(negedge clk);
        checks++;
        if (div_start_o !== 1'b0 || div_annul_o !== 1'b0 || stallreq_o !== 1'b0 || whilo_o !== 1'b0 ||
            hi_o !== 32'd0 || lo_o !== 32'd0 || div_op_o !== 6'd0) begin
            errors++;
            $display("FAIL %s_idle: start=%b annul=%b stall=%b whilo=%b hi=%h lo=%h op=%h, want all 0",
                     tag, div_start_o, div_annul_o, stallreq_o, whilo_o, hi_o, lo_o, div_op_o);
        end
        step();
    endtask

    task automatic test_reset();
        aluop_i = OP_DIVU; reg1_i = 32'd50; reg2_i = 32'd5; valid_i = 1'b1;
        #2;
        checks++;
        if (div_start_o !== 1'b0 || div_annul_o !== 1'b0 || stallreq_o !== 1'b0 || whilo_o !== 1'b0 ||
            hi_o !== 32'd0 || lo_o !== 32'd0 || div_op_o !== 6'd0 || div_opdata1_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b annul=%b stall=%b whilo=%b op=%h, want all 0",
                     div_start_o, div_annul_o, stallreq_o, whilo_o, div_op_o);
        end
        valid_i = 1'b0; aluop_i = '0;
        step(); step();
        rst = 1'b0;
        idle_check("post_reset");
    endtask

    task automatic test_directed();
        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        idle_check("div_m7_2");
        run_div(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, "divu_max_16");
        idle_check("divu_max_16");
        run_div(OP_DIV, 32'd1234, 32'd0, 1'b0, "div_by_zero");
        idle_check("div_by_zero");
    endtask

    task automatic test_back_to_back();
        run_div(OP_DIVU, 32'd100, 32'd7, 1'b0, "b2b_first");
        run_div(OP_DIVU, 32'd9, 32'd3, 1'b1, "b2b_second");
        idle_check("b2b");
    endtask

    task automatic test_flush();
        // flush in IDLE suppresses issue
        aluop_i = OP_DIVU; reg1_i = 32'd77; reg2_i = 32'd3; valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (div_start_o !== 1'b0 || stallreq_o !== 1'b0 || div_annul_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: start=%b stall=%b annul=%b, want 0 0 0", div_start_o, stallreq_o, div_annul_o);
        end
        step();
        flush_i = 1'b0; reg1_i = 32'd1000; reg2_i = 32'd7;
        repeat (10) step();
        flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (div_start_o !== 1'b0 || div_annul_o !== 1'b1 || whilo_o !== 1'b0 || stallreq_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy: start=%b annul=%b whilo=%b stall=%b, want 0 1 0 0",
                     div_start_o, div_annul_o, whilo_o, stallreq_o);
        end
        step();
        flush_i = 1'b0;
        // request still presented during FLUSH and must be ignored
        for (int i = 0; i < DC; i++) begin
            @(negedge clk);
            checks++;
            if (div_annul_o !== 1'b1 || div_start_o !== 1'b0 || stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_hold%0d: annul=%b start=%b stall=%b whilo=%b, want 1 0 0 0",
                         i, div_annul_o, div_start_o, stallreq_o, whilo_o);
            end
            step();
        end
        valid_i = 1'b0; aluop_i = '0;
        idle_check("flush_end");
        run_div(OP_DIVU, 32'd8, 32'd2, 1'b0, "after_flush");
        idle_check("after_flush");
    endtask

    task automatic test_reset_mid_busy();
        int pulses;
        aluop_i = OP_DIV; reg1_i = 32'd5000; reg2_i = 32'd13; valid_i = 1'b1;
        repeat (20) step();
        rst = 1'b1;
        #1;
        checks++;
        if (div_start_o !== 1'b0 || stallreq_o !== 1'b0 || whilo_o !== 1'b0 || div_annul_o !== 1'b0 ||
            div_op_o !== 6'd0 || div_opdata1_o !== 32'd0 || div_opdata2_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: start=%b stall=%b whilo=%b annul=%b op=%h, want all 0",
                     div_start_o, stallreq_o, whilo_o, div_annul_o, div_op_o);
        end
        valid_i = 1'b0; aluop_i = '0;
        step();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (whilo_o === 1'b1) pulses++;
            step();
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_no_whilo: pulses=%0d, want 0", pulses);
        end
        run_div(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, "after_reset");
        idle_check("after_reset");
    endtask

    task automatic test_random();
        logic [5:0]  op, nop;
        logic [31:0] a, b;
        for (int n = 0; n < 10; n++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                nop = 6'($urandom);
                if (nop == OP_DIV || nop == OP_DIVU) nop = 6'd0;
                aluop_i = nop; valid_i = 1'($urandom); reg1_i = $urandom; reg2_i = $urandom;
                idle_check("rand_nondiv");
            end
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            run_div(op, a, b, 1'b0, "rand");
            idle_check("rand");
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
